// File: rtl/player_motion_ctrl.sv
// Player movement controller: samples buttons on a rate tick, proposes a move,
// checks it with an external collision checker and slides along walls on rejection.
module player_motion_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int UPDATE_HZ   = 100,
    parameter int STEP        = 1,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 620,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 460,
    parameter int X_INIT      = 310,
    parameter int Y_INIT      = 220,
    parameter int CHK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       mode,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    output logic       chk_req,
    output logic [9:0] chk_x,
    output logic [9:0] chk_y,
    input  logic       chk_ack,
    input  logic       chk_ok,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] heading,
    output logic       moved,
    output logic       busy
);
    localparam int P  = CLK_HZ / UPDATE_HZ;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam int TW = $clog2(CHK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SAMPLE, WAIT, RETRY, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick_pend_q, tick_pend_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic [2:0]         head_q, head_d;
    logic signed [1:0]  dx_q, dx_d, dy_q, dy_d;
    logic [1:0]         att_q, att_d;
    logic               chk_req_q, chk_req_d;
    logic [9:0]         chk_x_q, chk_x_d, chk_y_q, chk_y_d;
    logic               moved_q, moved_d;
    logic [TW-1:0]      to_q, to_d;
    logic               tick;

    function automatic logic [9:0] step_clamp(input logic [9:0] pos, input logic signed [1:0] d,
                                              input int lo, input int hi);
        int c;
        c = int'(pos) + int'(d) * STEP;
        if (c < lo) c = lo;
        if (c > hi) c = hi;
        return c[9:0];
    endfunction

    // Unit vector per heading; screen y grows downwards, so "north" is -1.
    function automatic logic signed [3:0] head_vec(input logic [2:0] h);
        case (h)
            3'd0:    return {2'sb01, 2'sb00};
            3'd1:    return {2'sb01, 2'sb11};
            3'd2:    return {2'sb00, 2'sb11};
            3'd3:    return {2'sb11, 2'sb11};
            3'd4:    return {2'sb11, 2'sb00};
            3'd5:    return {2'sb11, 2'sb01};
            3'd6:    return {2'sb00, 2'sb01};
            default: return {2'sb01, 2'sb01};
        endcase
    endfunction

    assign tick = (tick_cnt_q == CW'(P - 1));

    // Button decode for SAMPLE: new heading and the requested direction.
    logic [2:0]        head_n;
    logic signed [1:0] dx_s, dy_s;
    logic signed [3:0] hv;
    always_comb begin
        head_n = head_q;
        dx_s   = 2'sb00;
        dy_s   = 2'sb00;
        hv     = 4'sb0000;
        if (mode) begin
            if (left && !right)      head_n = head_q + 3'd1;
            else if (right && !left) head_n = head_q - 3'd1;
            hv = head_vec(head_n);
            if (up && !down) begin
                dx_s = hv[3:2];
                dy_s = hv[1:0];
            end else if (down && !up) begin
                dx_s = -hv[3:2];
                dy_s = -hv[1:0];
            end
        end else begin
            if (right && !left)      dx_s = 2'sb01;
            else if (left && !right) dx_s = 2'sb11;
            if (down && !up)         dy_s = 2'sb01;
            else if (up && !down)    dy_s = 2'sb11;
        end
    end

    // Attempt 0 = full move, 1 = x only, 2 = y only.
    logic signed [1:0] dsel_x, dsel_y;
    logic [9:0]        nx, ny;
    logic [9:0]        cand_x [3];
    logic [9:0]        cand_y [3];
    logic [2:0]        axis_ok, avail;
    logic [2:0]        start_idx;
    logic              found;
    logic [1:0]        pick;

    assign dsel_x  = (state_q == SAMPLE) ? dx_s : dx_q;
    assign dsel_y  = (state_q == SAMPLE) ? dy_s : dy_q;
    assign nx      = step_clamp(x_q, dsel_x, X_MIN, X_MAX);
    assign ny      = step_clamp(y_q, dsel_y, Y_MIN, Y_MAX);
    assign axis_ok = {dsel_y != 2'sb00, dsel_x != 2'sb00, (dsel_x != 2'sb00) || (dsel_y != 2'sb00)};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_att
            assign cand_x[gi] = (gi == 2) ? x_q : nx;
            assign cand_y[gi] = (gi == 1) ? y_q : ny;
            // A clamped proposal that goes nowhere counts as already rejected.
            assign avail[gi]  = axis_ok[gi] && ((cand_x[gi] != x_q) || (cand_y[gi] != y_q));
        end
    endgenerate

    assign start_idx = (state_q == SAMPLE) ? 3'd0 : ({1'b0, att_q} + 3'd1);

    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (avail[k] && (k >= int'(start_idx))) begin
                found = 1'b1;
                pick  = 2'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + CW'(1);
        tick_pend_d = tick_pend_q | tick;
        x_d         = x_q;
        y_d         = y_q;
        head_d      = head_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        att_d       = att_q;
        chk_req_d   = chk_req_q;
        chk_x_d     = chk_x_q;
        chk_y_d     = chk_y_q;
        moved_d     = 1'b0;
        to_d        = to_q;
        case (state_q)
            IDLE: begin
                if ((tick_pend_q || tick) && enable) begin
                    state_d     = SAMPLE;
                    tick_pend_d = 1'b0;
                end
            end
            SAMPLE, RETRY: begin
                if (state_q == SAMPLE) begin
                    head_d = head_n;
                    dx_d   = dx_s;
                    dy_d   = dy_s;
                end
                if (found) begin
                    chk_req_d = 1'b1;
                    chk_x_d   = cand_x[pick];
                    chk_y_d   = cand_y[pick];
                    att_d     = pick;
                    to_d      = '0;
                    state_d   = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (chk_ack) begin
                    chk_req_d = 1'b0;
                    state_d   = chk_ok ? COMMIT : RETRY;
                end else if (to_q == TW'(CHK_TIMEOUT - 1)) begin
                    chk_req_d = 1'b0;
                    state_d   = RETRY;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            COMMIT: begin
                x_d     = chk_x_q;
                y_d     = chk_y_q;
                moved_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            tick_pend_q <= 1'b0;
            x_q         <= 10'(X_INIT);
            y_q         <= 10'(Y_INIT);
            head_q      <= 3'd0;
            dx_q        <= 2'sb00;
            dy_q        <= 2'sb00;
            att_q       <= 2'd0;
            chk_req_q   <= 1'b0;
            chk_x_q     <= 10'(X_INIT);
            chk_y_q     <= 10'(Y_INIT);
            moved_q     <= 1'b0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_pend_q <= tick_pend_d;
            x_q         <= x_d;
            y_q         <= y_d;
            head_q      <= head_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            att_q       <= att_d;
            chk_req_q   <= chk_req_d;
            chk_x_q     <= chk_x_d;
            chk_y_q     <= chk_y_d;
            moved_q     <= moved_d;
            to_q        <= to_d;
        end
    end

    assign chk_req = chk_req_q;
    assign chk_x   = chk_x_q;
    assign chk_y   = chk_y_q;
    assign x_pos   = x_q;
    assign y_pos   = y_q;
    assign heading = head_q;
    assign moved   = moved_q;
    assign busy    = (state_q != IDLE);
endmodule
